// File: rtl/cbfp0_pkg.sv
// Shared widths, limits and the FIFO entry type for the CBFP0 shift buffer.
package cbfp0_pkg;

    localparam int CBFP0_IDX_W         = 5;
    localparam int CBFP0_BLK_PER_FRAME = 8;
    localparam int CBFP0_MAX_SHIFT     = 12;

    typedef struct packed {
        logic [CBFP0_IDX_W-1:0]                 shift;
        logic [$clog2(CBFP0_BLK_PER_FRAME)-1:0] blk;
    } shift_entry_t;

endpackage

// File: rtl/cbfp0_sat_shift.sv
// Combinational clamp of a block's minimum sign-bit count to the largest shift the normalizer supports.
module cbfp0_sat_shift
    import cbfp0_pkg::*;
#(
    parameter int IDX_W     = CBFP0_IDX_W,
    parameter int MAX_SHIFT = CBFP0_MAX_SHIFT
) (
    input  logic [IDX_W-1:0] min_idx_i,
    output logic [IDX_W-1:0] sat_o
);

    localparam logic [IDX_W-1:0] MAX_C = IDX_W'(MAX_SHIFT);

    assign sat_o = (min_idx_i > MAX_C) ? MAX_C : min_idx_i;

endmodule

// File: rtl/cbfp0_shift_buf.sv
// Queues saturated per-block shift amounts, tagged with their block index, for the CBFP0 normalizer.
module cbfp0_shift_buf
    import cbfp0_pkg::*;
#(
    parameter int IDX_W         = CBFP0_IDX_W,
    parameter int DEPTH         = 8,
    parameter int BLK_PER_FRAME = CBFP0_BLK_PER_FRAME,
    parameter int MAX_SHIFT     = CBFP0_MAX_SHIFT
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             clr,
    input  logic                             min_fin_en,
    input  logic [IDX_W-1:0]                 min_idx,
    input  logic                             shift_rd_en,
    output logic [IDX_W-1:0]                 shift_out,
    output logic [$clog2(BLK_PER_FRAME)-1:0] blk_idx,
    output logic                             shift_valid,
    output logic                             buf_full,
    output logic                             frame_done,
    output logic                             ovf_flag,
    output logic                             udf_flag
);

    localparam int BLK_W = $clog2(BLK_PER_FRAME);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [BLK_W-1:0] LAST_BLK_C = BLK_W'(BLK_PER_FRAME - 1);

    shift_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [BLK_W-1:0] wpos_q, wpos_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             frame_done_q, frame_done_d;

    logic [IDX_W-1:0] sat;
    logic             empty;
    logic             full;
    logic             push_ok;
    logic             pop_ok;
    shift_entry_t     wr_entry;
    shift_entry_t     head_raw;
    shift_entry_t     head;

    cbfp0_sat_shift #(
        .IDX_W     (IDX_W),
        .MAX_SHIFT (MAX_SHIFT)
    ) u_sat (
        .min_idx_i (min_idx),
        .sat_o     (sat)
    );

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    assign push_ok = min_fin_en && (!full || shift_rd_en);
    assign pop_ok  = shift_rd_en && !empty;

    always_comb begin
        wr_entry       = '0;
        wr_entry.shift = sat;
        wr_entry.blk   = wpos_q;
    end

    assign head_raw = mem_q[rd_ptr_q];
    assign head     = empty ? '0 : head_raw;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        wpos_d       = wpos_q;
        ovf_d        = ovf_q;
        udf_d        = udf_q;
        frame_done_d = 1'b0;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            wpos_d   = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                wpos_d   = wpos_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d      = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
            ovf_d        = ovf_q | (min_fin_en & ~push_ok);
            udf_d        = udf_q | (shift_rd_en & empty);
            frame_done_d = pop_ok && (head_raw.blk == LAST_BLK_C);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wpos_q       <= '0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            wpos_q       <= wpos_d;
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Storage carries no reset; empty-state outputs are masked by the head mux instead.
    always_ff @(posedge clk) begin
        if (push_ok && !clr) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign shift_out   = head.shift;
    assign blk_idx     = head.blk;
    assign shift_valid = !empty;
    assign buf_full    = full;
    assign frame_done  = frame_done_q;
    assign ovf_flag    = ovf_q;
    assign udf_flag    = udf_q;

endmodule

// File: tb/tb_cbfp0_shift_buf.sv
// Directed self-checking bench for cbfp0_shift_buf.
module tb_cbfp0_shift_buf;

    logic       clk = 1'b0;
    logic       rstn;
    logic       clr;
    logic       min_fin_en;
    logic [4:0] min_idx;
    logic       shift_rd_en;
    logic [4:0] shift_out;
    logic [2:0] blk_idx;
    logic       shift_valid;
    logic       buf_full;
    logic       frame_done;
    logic       ovf_flag;
    logic       udf_flag;

    int checks = 0;
    int errors = 0;

    int t1_in  [8] = '{3, 5, 0, 12, 13, 31, 7, 1};
    int t1_exp [8] = '{3, 5, 0, 12, 12, 12, 7, 1};

    always #5 clk = ~clk;

    cbfp0_shift_buf dut (
        .clk         (clk),
        .rstn        (rstn),
        .clr         (clr),
        .min_fin_en  (min_fin_en),
        .min_idx     (min_idx),
        .shift_rd_en (shift_rd_en),
        .shift_out   (shift_out),
        .blk_idx     (blk_idx),
        .shift_valid (shift_valid),
        .buf_full    (buf_full),
        .frame_done  (frame_done),
        .ovf_flag    (ovf_flag),
        .udf_flag    (udf_flag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v);
        min_fin_en = 1'b1;
        min_idx    = 5'(v);
        tick();
        min_fin_en = 1'b0;
    endtask

    task automatic pop();
        shift_rd_en = 1'b1;
        tick();
        shift_rd_en = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        rstn        = 1'b0;
        clr         = 1'b0;
        min_fin_en  = 1'b0;
        min_idx     = '0;
        shift_rd_en = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(shift_valid), 0);
        chk("rst_shift", 32'(shift_out), 0);
        chk("rst_blk", 32'(blk_idx), 0);
        chk("rst_full", 32'(buf_full), 0);
        chk("rst_fd", 32'(frame_done), 0);
        chk("rst_flags", {30'd0, ovf_flag, udf_flag}, 0);
        rstn = 1'b1;
        tick();

        // 1: one frame spaced 4 cycles apart, then drain back-to-back
        for (int i = 0; i < 8; i++) begin
            push(t1_in[i]);
            if (i == 0) begin
                chk("t1_first_valid", 32'(shift_valid), 1);
                chk("t1_first_shift", 32'(shift_out), 3);
            end
            tick(); tick(); tick();
        end
        chk("t1_full", 32'(buf_full), 1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_shift%0d", i), 32'(shift_out), 32'(t1_exp[i]));
            chk($sformatf("t1_blk%0d", i), 32'(blk_idx), 32'(i));
            chk($sformatf("t1_fd_low%0d", i), 32'(frame_done), 0);
            pop();
        end
        chk("t1_fd_pulse", 32'(frame_done), 1);
        chk("t1_empty", 32'(shift_valid), 0);
        chk("t1_empty_shift", 32'(shift_out), 0);
        tick();
        chk("t1_fd_drop", 32'(frame_done), 0);
        chk("t1_flags", {30'd0, ovf_flag, udf_flag}, 0);

        // 2: fill, overflow push dropped, wpos held
        for (int i = 0; i < 8; i++) push(i + 1);
        chk("t2_full", 32'(buf_full), 1);
        chk("t2_ovf_before", 32'(ovf_flag), 0);
        push(4);
        chk("t2_full_after", 32'(buf_full), 1);
        chk("t2_ovf", 32'(ovf_flag), 1);
        chk("t2_head", 32'(shift_out), 1);
        pop();
        push(6);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("t2_shift%0d", i), 32'(shift_out), 32'(i + 2));
            chk($sformatf("t2_blk%0d", i), 32'(blk_idx), 32'(i + 1));
            pop();
        end
        chk("t2_next_frame_shift", 32'(shift_out), 6);
        chk("t2_next_frame_blk", 32'(blk_idx), 0);
        pop();
        chk("t2_drained", 32'(shift_valid), 0);
        chk("t2_ovf_sticky", 32'(ovf_flag), 1);
        do_clr();
        chk("t2_clr_ovf", 32'(ovf_flag), 0);

        // 3: simultaneous push and pop on a full FIFO
        for (int i = 0; i < 8; i++) push(i);
        min_fin_en  = 1'b1;
        min_idx     = 5'd9;
        shift_rd_en = 1'b1;
        tick();
        min_fin_en  = 1'b0;
        shift_rd_en = 1'b0;
        chk("t3_full", 32'(buf_full), 1);
        chk("t3_ovf", 32'(ovf_flag), 0);
        chk("t3_udf", 32'(udf_flag), 0);
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("t3_shift%0d", i), 32'(shift_out), 32'(i));
            pop();
        end
        chk("t3_tail_shift", 32'(shift_out), 9);
        chk("t3_tail_blk", 32'(blk_idx), 0);
        pop();
        chk("t3_empty", 32'(shift_valid), 0);

        // 4: underflow, then pop+push on empty (no bypass)
        pop();
        chk("t4_udf", 32'(udf_flag), 1);
        chk("t4_valid0", 32'(shift_valid), 0);
        chk("t4_shift0", 32'(shift_out), 0);
        min_fin_en  = 1'b1;
        min_idx     = 5'd2;
        shift_rd_en = 1'b1;
        tick();
        min_fin_en  = 1'b0;
        shift_rd_en = 1'b0;
        chk("t4_valid1", 32'(shift_valid), 1);
        chk("t4_shift1", 32'(shift_out), 2);
        chk("t4_blk1", 32'(blk_idx), 1);
        pop();

        // 5: clr wins over a same-cycle push
        push(10);
        push(11);
        push(12);
        chk("t5_blk_head", 32'(blk_idx), 2);
        chk("t5_udf_pre", 32'(udf_flag), 1);
        clr        = 1'b1;
        min_fin_en = 1'b1;
        min_idx    = 5'd5;
        tick();
        clr        = 1'b0;
        min_fin_en = 1'b0;
        chk("t5_valid", 32'(shift_valid), 0);
        chk("t5_shift", 32'(shift_out), 0);
        chk("t5_flags", {30'd0, ovf_flag, udf_flag}, 0);
        chk("t5_full", 32'(buf_full), 0);
        push(7);
        chk("t5_next_shift", 32'(shift_out), 7);
        chk("t5_next_blk", 32'(blk_idx), 0);

        // 6: async reset mid-frame (5 queued, wpos 5)
        for (int i = 0; i < 4; i++) push(20);
        chk("t6_pre_valid", 32'(shift_valid), 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_async_valid", 32'(shift_valid), 0);
        chk("t6_async_shift", 32'(shift_out), 0);
        chk("t6_async_blk", 32'(blk_idx), 0);
        chk("t6_async_full", 32'(buf_full), 0);
        chk("t6_async_fd", 32'(frame_done), 0);
        #2;
        rstn = 1'b1;
        push(11);
        chk("t6_post_shift", 32'(shift_out), 11);
        chk("t6_post_blk", 32'(blk_idx), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cbfp0_shift_buf.md
Name: cbfp0_shift_buf

Overview:
- Stage directly downstream of the CBFP0 minimum-finish controller.
- On each min_fin_en pulse, captures the block's minimum redundant-sign-bit count (min_idx), saturates it to a legal shift amount, tags it with its block index and queues it in a small FIFO.
- The CBFP0 normalizer pops one entry per data block to scale the block and forward the exponent.
- One frame is 8 blocks, matching the 8 min_fin_en pulses the controller emits per min_4s_en.

Parameters:
- IDX_W, 5, width of min_idx and shift_out.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- BLK_PER_FRAME, 8, blocks per frame; power of two.
- MAX_SHIFT, 12, saturation ceiling for the shift amount.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush of FIFO, counters and flags.
- min_fin_en  in  1  push strobe, single-cycle pulse.
- min_idx  in  IDX_W  block minimum sign-bit count, valid with min_fin_en.
- shift_rd_en  in  1  pop strobe from the normalizer.
- shift_out  out  IDX_W  head-entry shift amount.
- blk_idx  out  clog2(BLK_PER_FRAME)  head-entry block index.
- shift_valid  out  1  FIFO not empty.
- buf_full  out  1  count == DEPTH.
- frame_done  out  1  one-cycle pulse after the last block of a frame is popped.
- ovf_flag  out  1  sticky: a push was dropped.
- udf_flag  out  1  sticky: a pop occurred while empty.

Behaviour:
Reset (async, rstn low) and clr (sync, clk edge) clear everything:
- wr_ptr, rd_ptr, count, push block counter, all flags and frame_done go to 0.
- Memory contents do not matter.
- shift_out and blk_idx read 0 while empty (output mux forced to 0 when count == 0).
- clr has priority over a push or pop in the same cycle.

Push (min_fin_en = 1):
- Stored value is sat = (min_idx > MAX_SHIFT) ? MAX_SHIFT : min_idx.
- Stored tag is the push block counter (wpos).
- wpos increments modulo BLK_PER_FRAME on every accepted push.
- Push is accepted if count < DEPTH, or if count == DEPTH and shift_rd_en is asserted in the same cycle.
- Otherwise the push is dropped: ovf_flag is set and wpos does not advance.

Pop (shift_rd_en = 1):
- Accepted if count > 0; rd_ptr then increments modulo DEPTH.
- If count == 0 the pop is ignored and udf_flag is set.
- There is no bypass: a simultaneous push and pop while empty stores the push, and sets udf_flag.

Count and pointers:
- count' = count + accepted_push - accepted_pop.
- Pointers wrap modulo DEPTH.

Outputs:
- shift_out and blk_idx come combinationally from the registered array at rd_ptr.
- shift_valid = (count != 0); buf_full = (count == DEPTH); both are derived from registers.
- Latency: a push at edge N makes shift_valid high and shift_out valid from edge N onward, i.e. in cycle N+1.

frame_done:
- Registered pulse, high for the one cycle following the edge on which an entry with blk_idx == BLK_PER_FRAME-1 is accepted as a pop.

Flags:
- ovf_flag and udf_flag stay set until reset or clr.

Input assumptions:
- Back-to-back min_fin_en pulses are legal (the upstream spacing is 4 cycles, but the block must not depend on it).
- Any min_idx value is legal.

Decomposition:
- Package cbfp0_pkg holds:
  - localparams CBFP0_IDX_W = 5, CBFP0_BLK_PER_FRAME = 8, CBFP0_MAX_SHIFT = 12;
  - typedef shift_entry_t, a packed struct of shift (IDX_W) and blk (clog2 of BLK_PER_FRAME).
- Natural sub-module: cbfp0_sat_shift, a combinational saturating clamp of min_idx to MAX_SHIFT.
- The FIFO and counters stay in the top module.

Test Plan:
1. Reset then 8 pushes, 4 cycles apart, min_idx = 3, 5, 0, 12, 13, 31, 7, 1; then 8 consecutive pops.
   - Required: shift_out = 3, 5, 0, 12, 12, 12, 7, 1 and blk_idx = 0..7.
   - frame_done high exactly one cycle, after the 8th pop.
   - No flags set.
2. 8 pushes with no pop, then a 9th push with min_idx = 4.
   - Required: buf_full = 1, ovf_flag = 1, the 9th value is absent.
   - The next frame's first accepted push carries blk_idx = 0.
3. Full FIFO, simultaneous push (min_idx = 9) and pop.
   - Required: count stays 8, ovf_flag = 0, and the entry at the tail is 9.
4. Empty FIFO, shift_rd_en alone, then shift_rd_en together with min_fin_en (min_idx = 2).
   - Required: udf_flag = 1 and shift_valid = 0 after the first.
   - After the second: shift_valid = 1 and shift_out = 2.
5. After 3 pushes, assert clr together with a push.
   - Required: the next cycle shows shift_valid = 0, shift_out = 0, flags 0, and the next push tagged blk_idx = 0.
6. rstn asserted mid-frame (5 entries queued, wpos = 5).
   - Required: all outputs 0 immediately (asynchronously); after release, a push gets blk_idx = 0.
